// File: rtl/saucer_scheduler.sv
// Saucer pass scheduler: random wait, horizontal flight, hit/explosion and score handshake.
// Optional random entry side selected by defining SAUCER_RANDOM_DIR_EN.
module saucer_scheduler #(
  parameter logic [10:0] WAIT_MIN   = 11'd600,
  parameter logic [10:0] WAIT_MASK  = 11'd511,
  parameter logic [1:0]  MOVE_DIV   = 2'd3,
  parameter logic [5:0]  HIT_FRAMES = 6'd30,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        game_active,
  input  logic        restart,
  input  logic        hit,
  input  logic        score_ack,
  output logic [10:0] saucer_x,
  output logic        saucer_visible,
  output logic        saucer_exploding,
  output logic        score_req,
  output logic [8:0]  score_pts
);

  localparam logic [10:0] XLeft  = 11'h7E8;  // -24
  localparam logic [10:0] XRight = 11'd664;

  typedef enum logic [1:0] {StIdle, StWait, StFly, StExplode} state_e;

  state_e      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [10:0] wait_q, wait_d, x_q, x_d;
  logic [10:0] x_step, x_end, wait_load;
  logic [1:0]  step_q, step_d;
  logic [5:0]  hcnt_q, hcnt_d;
  logic        dir_q, dir_d, dir_entry;
  logic        req_q, req_d, vis_q, vis_d, expl_q, expl_d;
  logic [8:0]  pts_q, pts_d, pts_hit;

`ifdef SAUCER_RANDOM_DIR_EN
  assign dir_entry = lfsr_q[15];
`else
  assign dir_entry = 1'b1;
`endif

  assign wait_load = WAIT_MIN + (lfsr_q[10:0] & WAIT_MASK);
  assign x_step    = dir_q ? (x_q - 11'd1) : (x_q + 11'd1);
  assign x_end     = dir_q ? XLeft : XRight;

  always_comb begin
    pts_hit = 9'd50;
    unique case (lfsr_q[1:0])
      2'd0: pts_hit = 9'd50;
      2'd1: pts_hit = 9'd100;
      2'd2: pts_hit = 9'd150;
      2'd3: pts_hit = 9'd300;
    endcase
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    wait_d  = wait_q;
    step_d  = step_q;
    hcnt_d  = hcnt_q;
    x_d     = x_q;
    dir_d   = dir_q;
    req_d   = req_q & ~score_ack;
    pts_d   = pts_q;
    if (frame_tick && (state_q != StIdle)) begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
    if (restart || !game_active) begin
      // Leaving play drops everything, including a pending award; the LFSR keeps its phase.
      state_d = StIdle;
      wait_d  = '0;
      step_d  = '0;
      hcnt_d  = '0;
      x_d     = XLeft;
      dir_d   = 1'b0;
      req_d   = 1'b0;
      pts_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StWait;
          wait_d  = wait_load;
        end
        StWait: begin
          if (frame_tick) begin
            if (wait_q == 11'd0) begin
              state_d = StFly;
              dir_d   = dir_entry;
              x_d     = dir_entry ? XRight : XLeft;
              step_d  = '0;
            end else begin
              wait_d = wait_q - 11'd1;
            end
          end
        end
        StFly: begin
          if (hit) begin
            state_d = StExplode;
            hcnt_d  = '0;
            req_d   = 1'b1;
            // A still-pending award keeps its points until acknowledged.
            if (!req_q || score_ack) pts_d = pts_hit;
          end else if (frame_tick) begin
            if (step_q == MOVE_DIV - 2'd1) begin
              step_d = '0;
              x_d    = x_step;
              if (x_step == x_end) begin
                state_d = StWait;
                wait_d  = wait_load;
              end
            end else begin
              step_d = step_q + 2'd1;
            end
          end
        end
        StExplode: begin
          if (frame_tick) begin
            if (hcnt_q == HIT_FRAMES - 6'd1) begin
              state_d = StWait;
              wait_d  = wait_load;
              hcnt_d  = '0;
            end else begin
              hcnt_d = hcnt_q + 6'd1;
            end
          end
        end
      endcase
    end
    vis_d  = (state_d == StFly);
    expl_d = (state_d == StExplode);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      lfsr_q  <= LFSR_SEED;
      wait_q  <= '0;
      step_q  <= '0;
      hcnt_q  <= '0;
      x_q     <= XLeft;
      dir_q   <= 1'b0;
      req_q   <= 1'b0;
      pts_q   <= '0;
      vis_q   <= 1'b0;
      expl_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      wait_q  <= wait_d;
      step_q  <= step_d;
      hcnt_q  <= hcnt_d;
      x_q     <= x_d;
      dir_q   <= dir_d;
      req_q   <= req_d;
      pts_q   <= pts_d;
      vis_q   <= vis_d;
      expl_q  <= expl_d;
    end
  end

  assign saucer_x         = x_q;
  assign saucer_visible   = vis_q;
  assign saucer_exploding = expl_q;
  assign score_req        = req_q;
  assign score_pts        = pts_q;

endmodule

// File: tb/tb_saucer_scheduler.sv
// Directed bench for saucer_scheduler; awards are checked by a scoreboard monitor.
module tb_saucer_scheduler;

  localparam logic [10:0] XM24 = 11'h7E8;
  localparam logic [10:0] XM23 = 11'h7E9;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic        game_active = 1'b0;
  logic        restart = 1'b0;
  logic        hit = 1'b0;
  logic        score_ack = 1'b0;
  logic [10:0] saucer_x;
  logic        saucer_visible, saucer_exploding, score_req;
  logic [8:0]  score_pts;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [15:0] lfsr_m = 16'hACE1;
  bit          active = 1'b0;
  logic [8:0]  exp_q[$];

  saucer_scheduler #(
    .WAIT_MIN  (11'd4),
    .WAIT_MASK (11'd0),
    .MOVE_DIV  (2'd1),
    .HIT_FRAMES(6'd3),
    .LFSR_SEED (16'hACE1)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .frame_tick      (frame_tick),
    .game_active     (game_active),
    .restart         (restart),
    .hit             (hit),
    .score_ack       (score_ack),
    .saucer_x        (saucer_x),
    .saucer_visible  (saucer_visible),
    .saucer_exploding(saucer_exploding),
    .score_req       (score_req),
    .score_pts       (score_pts)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] adv(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [8:0] pts_of(input logic [1:0] b);
    case (b)
      2'd0:    return 9'd50;
      2'd1:    return 9'd100;
      2'd2:    return 9'd150;
      default: return 9'd300;
    endcase
  endfunction

  // Extra LFSR shifts needed so that lfsr[1:0]==3 when the saucer sits at x=300.
  function automatic int pick_k(input logic [15:0] l0);
    logic [15:0] l;
    for (int k = 0; k < 64; k++) begin
      l = l0;
      repeat (k + 369) l = adv(l);
      if (l[1:0] == 2'b11) return k;
    end
    return 0;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic cyc(input bit ft, input bit h, input bit ack);
    frame_tick = ft;
    hit        = h;
    score_ack  = ack;
    @(posedge clk);
    #1;
    if (ft && active) lfsr_m = adv(lfsr_m);
    frame_tick = 1'b0;
    hit        = 1'b0;
    score_ack  = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) cyc(1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_restart();
    restart = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    active  = 1'b0;
    restart = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    active  = 1'b1;
  endtask

  task automatic monitor();
    logic req_prev = 1'b0;
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (!rst && score_req && !req_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_award", 32'(score_pts), 32'hFFFF);
        end else begin
          e = exp_q.pop_front();
          check("award_pts", 32'(score_pts), 32'(e));
        end
      end
      req_prev = score_req;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, n;
    logic d;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_x", 32'(saucer_x), 32'(XM24));
    check("rst_vis", 32'(saucer_visible), 0);
    check("rst_expl", 32'(saucer_exploding), 0);
    check("rst_req", 32'(score_req), 0);
    check("rst_pts", 32'(score_pts), 0);
    ticks(3);
    check("idle_vis", 32'(saucer_visible), 0);

    game_active = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    active = 1'b1;
`ifdef SAUCER_RANDOM_DIR_EN
    ticks(4);
    d = lfsr_m[15];
    ticks(1);
    check("rnd_entry_x", 32'(saucer_x), d ? 32'd664 : 32'(XM24));
    ticks(1);
    check("rnd_step_x", 32'(saucer_x), d ? 32'd663 : 32'(XM23));
`else
    cyc(1'b0, 1'b1, 1'b0);
    check("wait_hit_ign", 32'(saucer_exploding), 0);
    ticks(4);
    check("wait_vis", 32'(saucer_visible), 0);
    ticks(1);
    check("fly_vis", 32'(saucer_visible), 1);
    check("fly_entry_x", 32'(saucer_x), 664);
    ticks(1);
    check("fly_step_x", 32'(saucer_x), 663);

    ticks(686);
    check("trav_pre_x", 32'(saucer_x), 32'(XM23));
    check("trav_pre_vis", 32'(saucer_visible), 1);
    ticks(1);
    check("trav_end_x", 32'(saucer_x), 32'(XM24));
    check("trav_end_vis", 32'(saucer_visible), 0);
    ticks(4);
    check("rewait_vis", 32'(saucer_visible), 0);
    ticks(1);
    check("refly_vis", 32'(saucer_visible), 1);
    check("refly_x", 32'(saucer_x), 664);

    // Hit at x=300 with lfsr[1:0]==3, phase shifted by aborted waits.
    do_restart();
    k = pick_k(lfsr_m);
    while (k > 0) begin
      n = (k > 4) ? 4 : k;
      ticks(n);
      do_restart();
      k -= n;
    end
    ticks(5 + 364);
    check("hit_pos_x", 32'(saucer_x), 300);
    exp_q.push_back(pts_of(lfsr_m[1:0]));
    cyc(1'b0, 1'b1, 1'b0);
    check("hit_expl", 32'(saucer_exploding), 1);
    check("hit_vis", 32'(saucer_visible), 0);
    check("hit_pts300", 32'(score_pts), 300);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, (i == 3), 1'b0);
      check("hold_req", 32'(score_req), 1);
      check("hold_pts", 32'(score_pts), 300);
    end
    cyc(1'b0, 1'b0, 1'b1);
    check("ack_clear", 32'(score_req), 0);
    ticks(2);
    check("expl_x", 32'(saucer_x), 300);
    check("expl_still", 32'(saucer_exploding), 1);
    cyc(1'b0, 1'b1, 1'b0);
    check("expl_hit_ign", 32'(score_req), 0);
    ticks(1);
    check("expl_done", 32'(saucer_exploding), 0);
    cyc(1'b0, 1'b0, 1'b1);
    check("ack_ign", 32'(score_req), 0);

    // Hit coinciding with the exit step.
    ticks(5);
    check("co_entry_x", 32'(saucer_x), 664);
    ticks(687);
    check("co_pre_x", 32'(saucer_x), 32'(XM23));
    exp_q.push_back(pts_of(lfsr_m[1:0]));
    cyc(1'b1, 1'b1, 1'b0);
    check("co_expl", 32'(saucer_exploding), 1);
    check("co_x", 32'(saucer_x), 32'(XM23));
    ticks(3);
    check("co_wait_expl", 32'(saucer_exploding), 0);
    check("co_req_kept", 32'(score_req), 1);
    cyc(1'b0, 1'b0, 1'b1);
    check("co_ack", 32'(score_req), 0);

    // First FLY cycle is hittable; restart then drops the award.
    ticks(5);
    exp_q.push_back(pts_of(lfsr_m[1:0]));
    cyc(1'b0, 1'b1, 1'b0);
    check("first_hit_expl", 32'(saucer_exploding), 1);
    check("first_hit_x", 32'(saucer_x), 664);
    check("first_hit_req", 32'(score_req), 1);
    restart = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    restart = 1'b0;
    active  = 1'b0;
    game_active = 1'b0;
    check("rs_req", 32'(score_req), 0);
    check("rs_pts", 32'(score_pts), 0);
    check("rs_x", 32'(saucer_x), 32'(XM24));
    check("rs_vis", 32'(saucer_visible), 0);
    check("rs_expl", 32'(saucer_exploding), 0);
    ticks(7);
    check("off_vis", 32'(saucer_visible), 0);
`endif
    cyc(1'b0, 1'b0, 1'b0);
    check("awards_left", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
